alu_seq_ctrl: RTL

- Multi-cycle sequencer in front of the 32-bit combinational ALU.
- Accepts one operation per start/done transaction and drives the ALU operand/select inputs.
- Shift ops (ALUSel 0110..1001) use the ALU's 1-bit shifter repeatedly, giving shift amounts of 0-31 (amount = b[4:0]). All other ops complete in one ALU cycle.
- Sits between the core control FSM and the ALU; result is registered.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: ALUSel operation codes, the
// controller state encoding and a helper that classifies shift operations.
//
// Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state for op 1011).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  // ALUSel codes understood by the downstream combinational ALU.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_ROL  = 4'b1001;
  localparam logic [3:0] ALU_ADD4 = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef ALU_SEQ_MUL_EN
    ST_DONE  = 3'd3,
    ST_MUL   = 3'd4
`else
    ST_DONE  = 3'd3
`endif
  } state_t;

  // Shift ops occupy the contiguous ALUSel range SRL..ROL; the ALU's shifter
  // only moves one bit per pass, so these need the iterative SHIFT state.
  function automatic logic is_shift(input logic [3:0] sel);
    return (sel >= ALU_SRL) && (sel <= ALU_ROL);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Multi-cycle sequencer in front of a combinational ALU. Accepts one
// operation per start/done transaction, steers the ALU operand/select inputs
// and registers the final ALU output as the result. Shift ops are performed
// as N single-bit passes through the ALU (N = b[SHAMT_W-1:0]).
//
// Optional feature macro: ALU_SEQ_MUL_EN -- op 1011 becomes an unsigned
// shift-and-add multiply (low WIDTH bits) over WIDTH MUL cycles. Without the
// macro 1011 is an undefined op and runs through EXEC like any other.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, op, a, b     request strobe and its operation/operands
//   busy, done, result  status, one-cycle completion pulse, registered result
//   alu_a, alu_b,
//   alu_sel, alu_en     drive to the ALU
//   alu_result          return from the ALU
//
// Handshake: start is sampled only in IDLE (busy=0 and done=0); a start seen
// in any other state is dropped without side effects. done pulses for exactly
// one cycle and result then holds until the next done.
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_en,
  input  logic [WIDTH-1:0]  alu_result
);

  state_t               state;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   cnt;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
`endif

  // -------------------------------------------------------------------------
  // Control FSM. done and busy are registered alongside the state so that
  // done==1 exactly in DONE and busy==1 exactly in the working states.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            acc  <= a;
            cnt  <= b[SHAMT_W-1:0];
            busy <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (op == ALU_MUL) begin
              // Counter runs all-ones down to zero: one MUL cycle per bit.
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '1;
              state  <= ST_MUL;
            end else
`endif
            // A zero-amount shift goes through EXEC; b[0]=0 there, so the
            // ALU shifts by nothing and returns a unchanged.
            if (is_shift(op) && (b[SHAMT_W-1:0] != '0)) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          result <= alu_result;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end

        ST_SHIFT: begin
          acc <= alu_result;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result <= alu_result;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end

`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Last partial product: alu_result already holds the final sum.
          if (cnt == '0) begin
            result <= alu_result;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          // Start is deliberately not sampled here.
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // ALU steering: depends only on state and latched operands, never on the
  // live request inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_en  = 1'b0;
    case (state)
      ST_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_sel = op_q;
        alu_en  = 1'b1;
      end
      ST_SHIFT: begin
        alu_a   = acc;
        alu_b   = {{(WIDTH-1){1'b0}}, 1'b1};
        alu_sel = op_q;
        alu_en  = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        alu_a   = acc;
        alu_b   = mplier[0] ? mcand : '0;
        alu_sel = ALU_ADD;
        alu_en  = 1'b1;
      end
`endif
      default: begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        alu_en  = 1'b0;
      end
    endcase
  end

endmodule
